// File: rtl/multiplexor_display_7seg.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// BCD digits are latched once per scan frame; leading zeros can be blanked.
module multiplexor_display_7seg #(
    parameter int unsigned PRESC_MAX   = 100000,
    parameter int unsigned PRESC_BITS  = 17,
    parameter int unsigned BLANK_CEROS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] millares,
    input  logic [3:0] centenas,
    input  logic [3:0] decenas,
    input  logic [3:0] unidades,
    output logic [3:0] anodos,
    output logic [6:0] segmentos,
    output logic       frame_fin
);

    localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(PRESC_MAX - 1);
    localparam logic [1:0]            IDX_LAST   = 2'd3;
    localparam logic [6:0]            SEG_OFF    = 7'b1111111;
    localparam logic [6:0]            SEG_DASH   = 7'b0111111;
    localparam logic [3:0]            AN_OFF     = 4'b1111;

    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            sh_mil_q, sh_mil_d;
    logic [3:0]            sh_cen_q, sh_cen_d;
    logic [3:0]            sh_dec_q, sh_dec_d;
    logic [3:0]            sh_uni_q, sh_uni_d;
    logic [3:0]            anodos_q, anodos_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_fin_q, frame_fin_d;

    logic       tick;
    logic       frame_end;
    logic       blank_mil, blank_cen, blank_dec;
    logic [3:0] digit_sel;
    logic       blank_sel;
    logic [6:0] seg_code;

    // Scan timing: prescaler, slot index and shadow latch.
    always_comb begin
        tick      = habilitar && (presc_q == PRESC_LAST);
        frame_end = tick && (idx_q == IDX_LAST);

        presc_d = presc_q;
        if (habilitar) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        idx_d = tick ? idx_q + 2'd1 : idx_q;

        sh_mil_d = sh_mil_q;
        sh_cen_d = sh_cen_q;
        sh_dec_d = sh_dec_q;
        sh_uni_d = sh_uni_q;
        if (frame_end) begin
            sh_mil_d = millares;
            sh_cen_d = centenas;
            sh_dec_d = decenas;
            sh_uni_d = unidades;
        end

        frame_fin_d = frame_end;
    end

    // Blanking uses only the shadow copy so a frame is always self-consistent.
    always_comb begin
        blank_mil = (BLANK_CEROS != 0) && (sh_mil_q == 4'd0);
        blank_cen = blank_mil && (sh_cen_q == 4'd0);
        blank_dec = blank_cen && (sh_dec_q == 4'd0);

        digit_sel = sh_uni_q;
        blank_sel = 1'b0;
        case (idx_q)
            2'd0: begin digit_sel = sh_uni_q; blank_sel = 1'b0;      end
            2'd1: begin digit_sel = sh_dec_q; blank_sel = blank_dec; end
            2'd2: begin digit_sel = sh_cen_q; blank_sel = blank_cen; end
            2'd3: begin digit_sel = sh_mil_q; blank_sel = blank_mil; end
            default: begin digit_sel = sh_uni_q; blank_sel = 1'b0; end
        endcase
    end

    always_comb begin
        seg_code = SEG_DASH;
        case (digit_sel)
            4'd0: seg_code = 7'b1000000;
            4'd1: seg_code = 7'b1111001;
            4'd2: seg_code = 7'b0100100;
            4'd3: seg_code = 7'b0110000;
            4'd4: seg_code = 7'b0011001;
            4'd5: seg_code = 7'b0010010;
            4'd6: seg_code = 7'b0000010;
            4'd7: seg_code = 7'b1111000;
            4'd8: seg_code = 7'b0000000;
            4'd9: seg_code = 7'b0010000;
            default: seg_code = SEG_DASH;
        endcase
    end

    always_comb begin
        anodos_d = AN_OFF;
        seg_d    = SEG_OFF;
        if (habilitar && !blank_sel) begin
            anodos_d = ~(4'b0001 << idx_q);
            seg_d    = seg_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            sh_mil_q    <= '0;
            sh_cen_q    <= '0;
            sh_dec_q    <= '0;
            sh_uni_q    <= '0;
            anodos_q    <= AN_OFF;
            seg_q       <= SEG_OFF;
            frame_fin_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            sh_mil_q    <= sh_mil_d;
            sh_cen_q    <= sh_cen_d;
            sh_dec_q    <= sh_dec_d;
            sh_uni_q    <= sh_uni_d;
            anodos_q    <= anodos_d;
            seg_q       <= seg_d;
            frame_fin_q <= frame_fin_d;
        end
    end

    assign anodos    = anodos_q;
    assign segmentos = seg_q;
    assign frame_fin = frame_fin_q;

endmodule

// File: tb/tb_multiplexor_display_7seg.sv
// Directed bench for multiplexor_display_7seg with a 4-cycle digit slot.
// Each frame is checked cycle by cycle against hand-written slot tables.
module tb_multiplexor_display_7seg;

    logic       clk;
    logic       reset;
    logic       habilitar;
    logic [3:0] millares, centenas, decenas, unidades;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    logic       frame_fin;

    int total = 0;
    int bad   = 0;

    // Slot s occupies an[4*s +: 4] and seg[7*s +: 7]; slot 0 = unidades.
    localparam logic [15:0] AN_ZERO = 16'b1111_1111_1111_1110;
    localparam logic [27:0] SG_ZERO = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
    localparam logic [15:0] AN_FULL = 16'b0111_1011_1101_1110;
    localparam logic [27:0] SG_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
    localparam logic [15:0] AN_0042 = 16'b1111_1111_1101_1110;
    localparam logic [27:0] SG_0042 = {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100};
    localparam logic [27:0] SG_10C5 = {7'b1111001, 7'b1000000, 7'b0111111, 7'b0010010};
    localparam logic [27:0] SG_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};

    multiplexor_display_7seg #(
        .PRESC_MAX  (4),
        .PRESC_BITS (2),
        .BLANK_CEROS(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .habilitar(habilitar),
        .millares (millares),
        .centenas (centenas),
        .decenas  (decenas),
        .unidades (unidades),
        .anodos   (anodos),
        .segmentos(segmentos),
        .frame_fin(frame_fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        cmp({tag, ".an"},  {3'b000, anodos}, 7'b0001111);
        cmp({tag, ".seg"}, segmentos, 7'b1111111);
        cmp({tag, ".ff"},  {6'd0, frame_fin}, 7'd0);
    endtask

    task automatic set_in(input logic [3:0] m, input logic [3:0] c,
                          input logic [3:0] d, input logic [3:0] u);
        millares = m;
        centenas = c;
        decenas  = d;
        unidades = u;
    endtask

    // Checks frame cycles first..last (1..16); slot = (cycle-1)/4, frame_fin only on cycle 16.
    task automatic check_run(input string tag, input logic [15:0] an_e, input logic [27:0] sg_e,
                             input int first, input int last);
        int s;
        for (int c = first; c <= last; c++) begin
            s = (c - 1) / 4;
            @(negedge clk);
            cmp($sformatf("%s.c%0d.an", tag, c),  {3'b000, anodos}, {3'b000, an_e[4*s +: 4]});
            cmp($sformatf("%s.c%0d.seg", tag, c), segmentos, sg_e[7*s +: 7]);
            cmp($sformatf("%s.c%0d.ff", tag, c),  {6'd0, frame_fin}, {6'd0, (c == 16)});
        end
    endtask

    initial begin
        reset     = 1'b1;
        habilitar = 1'b1;
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        #1;
        chk_dark("reset0");
        @(negedge clk);
        reset = 1'b0;

        // Shadow starts at zero: only unidades "0" lit; 1234 latched at frame end.
        check_run("post_reset", AN_ZERO, SG_ZERO, 1, 16);
        check_run("f1234", AN_FULL, SG_1234, 1, 16);

        set_in(4'd0, 4'd0, 4'd4, 4'd2);
        check_run("f1234b", AN_FULL, SG_1234, 1, 16);
        check_run("f0042", AN_0042, SG_0042, 1, 16);

        set_in(4'd0, 4'd0, 4'd0, 4'd0);
        check_run("f0042b", AN_0042, SG_0042, 1, 16);
        check_run("f0000", AN_ZERO, SG_ZERO, 1, 16);

        set_in(4'd1, 4'd0, 4'hC, 4'd5);
        check_run("f0000b", AN_ZERO, SG_ZERO, 1, 16);
        check_run("f10C5", AN_FULL, SG_10C5, 1, 16);

        // Inputs change mid-frame while idx==1: invisible until the next latch.
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        check_run("f10C5b", AN_FULL, SG_10C5, 1, 16);
        check_run("chg_a", AN_FULL, SG_1234, 1, 6);
        set_in(4'd5, 4'd6, 4'd7, 4'd8);
        check_run("chg_b", AN_FULL, SG_1234, 7, 16);
        check_run("f5678", AN_FULL, SG_5678, 1, 16);

        // Pause mid-slot 0 for 10 clk, then the slot finishes its remaining cycles.
        check_run("hab_a", AN_FULL, SG_5678, 1, 2);
        habilitar = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_dark($sformatf("hab_off%0d", i));
        end
        habilitar = 1'b1;
        check_run("hab_b", AN_FULL, SG_5678, 3, 16);

        // Asynchronous reset mid-frame, away from any clock edge.
        check_run("rst_a", AN_FULL, SG_5678, 1, 7);
        #2 reset = 1'b1;
        #1 chk_dark("rst_async");
        @(negedge clk);
        chk_dark("rst_hold");
        reset = 1'b0;
        check_run("rst_b", AN_ZERO, SG_ZERO, 1, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
